// File: rtl/triad_pkg.sv
// Shared definitions for the triad frame arbiter: frame width, FSM encoding,
// and the default transmitter-ack timeout.
package triad_pkg;

  localparam int FRAME_W_DEF        = 102;
  localparam int TIMEOUT_CYCLES_DEF = 1200000;  // 100 ms at 12 MHz

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first eligible channel at or after i_rr_ptr,
// wrapping modulo N_CH. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic [N_CH-1:0] i_eligible,
  input  logic [ID_W-1:0] i_rr_ptr,
  output logic [ID_W-1:0] o_grant,
  output logic            o_grant_valid
);

  int w_dist;
  int w_best;

  // Pick the eligible channel with the smallest forward distance from the pointer.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_dist        = 0;
    w_best        = N_CH;
    for (int k = 0; k < N_CH; k++) begin
      w_dist = k - int'(i_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + N_CH;
      if (i_eligible[k] && (w_dist < w_best)) begin
        w_best        = w_dist;
        o_grant       = ID_W'(k);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/triad_frame_arbiter.sv
// Collects frames from N_TRIADS triad managers round-robin, buffers one, and
// presents it tagged with its triad index. Optional macro: ARB_TIMEOUT_EN.
module triad_frame_arbiter
  import triad_pkg::*;
#(
  parameter int N_TRIADS       = 4,
  parameter int FRAME_W        = FRAME_W_DEF,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk_12MHz,
  input  logic                         rst_n,
  input  logic [N_TRIADS-1:0]          data_avl,
  input  logic [N_TRIADS*FRAME_W-1:0]  sensor_iterations,
  output logic [N_TRIADS-1:0]          reset_parser,
  output logic                         frame_avl,
  output logic [FRAME_W-1:0]           frame_data,
  output logic [ID_W-1:0]              frame_triad_id,
  input  logic                         frame_done,
  output logic                         timeout_evt
);

  arb_state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_grant;
  logic [N_TRIADS-1:0]   r_release_mask, w_eligible, w_grant_oh;
  logic                  w_grant_valid, w_fire, w_to_hit;
  logic [FRAME_W-1:0]    r_frame_data;
  logic [ID_W-1:0]       r_triad_id;

  assign w_eligible = data_avl & ~r_release_mask;

  rr_arbiter #(.N_CH(N_TRIADS), .ID_W(ID_W)) u_rr (
    .i_eligible   (w_eligible),
    .i_rr_ptr     (r_rr_ptr),
    .o_grant      (w_grant),
    .o_grant_valid(w_grant_valid)
  );

  // Grant is gated by rst_n so no release pulse leaks out while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: if (w_grant_valid && rst_n) begin
        w_fire      = 1'b1;
        w_state_nxt = PRESENT;
      end
      PRESENT: if (frame_done || w_to_hit) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_grant_oh = w_fire ? (N_TRIADS'(1) << w_grant) : '0;

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Mask clears once data_avl is seen low; a same-cycle grant re-sets it.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_release_mask <= '0;
      r_rr_ptr       <= '0;
      r_frame_data   <= '0;
      r_triad_id     <= '0;
    end else begin
      r_release_mask <= (r_release_mask & data_avl) | w_grant_oh;
      if (w_fire) begin
        r_frame_data <= sensor_iterations[int'(w_grant)*FRAME_W +: FRAME_W];
        r_triad_id   <= w_grant;
        r_rr_ptr     <= (w_grant == ID_W'(N_TRIADS-1)) ? '0 : w_grant + ID_W'(1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timeout;

  assign w_to_hit = (r_state == PRESENT) && !frame_done &&
                    (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (w_fire)                   r_to_cnt <= '0;
      else if (r_state == PRESENT)  r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  assign timeout_evt = r_timeout;
`else
  assign w_to_hit    = (TIMEOUT_CYCLES == 0) && 1'b0;
  assign timeout_evt = 1'b0;
`endif

  assign reset_parser   = w_grant_oh;
  assign frame_avl      = (r_state == PRESENT);
  assign frame_data     = r_frame_data;
  assign frame_triad_id = r_triad_id;

endmodule

// File: tb/tb_triad_frame_arbiter.sv
// Randomised and directed bench for triad_frame_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_triad_frame_arbiter;

  localparam int N   = 4;
  localparam int W   = 102;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic             clk_12MHz = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     data_avl = '0;
  logic [N*W-1:0]   sensor_iterations = '0;
  logic             frame_done = 1'b0;
  logic [N-1:0]     reset_parser;
  logic             frame_avl;
  logic [W-1:0]     frame_data;
  logic [IDW-1:0]   frame_triad_id;
  logic             timeout_evt;

  triad_frame_arbiter #(.N_TRIADS(N), .FRAME_W(W), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_12MHz        (clk_12MHz),
    .rst_n            (rst_n),
    .data_avl         (data_avl),
    .sensor_iterations(sensor_iterations),
    .reset_parser     (reset_parser),
    .frame_avl        (frame_avl),
    .frame_data       (frame_data),
    .frame_triad_id   (frame_triad_id),
    .frame_done       (frame_done),
    .timeout_evt      (timeout_evt)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "holding a frame", "in the one-cycle gap", pointer, masks.
  bit           m_hold, m_gap, m_to;
  int           m_ptr, m_age, m_id;
  bit [N-1:0]   m_mask;
  logic [W-1:0] m_data;

  function automatic int m_pick();
    if (m_hold || m_gap) return -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (data_avl[k] && !m_mask[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rp();
    int g = m_pick();
    logic [N-1:0] v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_frame();
    return W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic m_reset();
    m_hold = 0; m_gap = 0; m_to = 0; m_ptr = 0; m_age = 0; m_id = 0;
    m_mask = '0; m_data = '0;
  endtask

  // Advance model across one clock edge using the current inputs, then the clock.
  task automatic tick();
    int g;
    bit [N-1:0] nm;
    g = m_pick();
    nm = m_mask & data_avl;
    m_to = 0;
    if (g >= 0) begin
      nm[g] = 1; m_data = sensor_iterations[g*W +: W]; m_id = g;
      m_ptr = (g + 1) % N; m_hold = 1; m_age = 0;
    end else if (m_hold && frame_done) begin
      m_hold = 0; m_gap = 1;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_hold && m_age == TO - 1) begin
      m_hold = 0; m_gap = 1; m_to = 1;
    end
`endif
    else if (m_hold) m_age++;
    else if (m_gap) m_gap = 0;
    m_mask = nm;
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic settle();
    data_avl = '0;
    frame_done = m_hold;
    tick();
    frame_done = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0; data_avl = '1; frame_done = 0;
    for (int k = 0; k < N; k++) sensor_iterations[k*W +: W] = rand_frame();
    #12;
    n_vec++;
    if ({reset_parser, frame_avl, frame_triad_id, timeout_evt} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl got rp=%b avl=%b id=%0d to=%b expected all 0",
               reset_parser, frame_avl, frame_triad_id, timeout_evt);
    end
    n_vec++;
    if (frame_data !== '0) begin
      n_err++; $display("FAIL reset_data got %h expected 0", frame_data);
    end
    @(posedge clk_12MHz); #1;
    data_avl = '0; m_reset(); rst_n = 1;
  endtask

  task automatic test_round_robin();
    int t_drop[N], t_raise[N], t_done;
    int got[$];
    int want[6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] rp;
    bit prev_avl = 0;
    for (int k = 0; k < N; k++) begin t_drop[k] = -1; t_raise[k] = -1; end
    t_done = -1;
    data_avl = '1;
    for (int c = 0; c < 45; c++) begin
      for (int k = 0; k < N; k++) begin
        if (t_drop[k] == c)  data_avl[k] = 1'b0;
        if (t_raise[k] == c) data_avl[k] = 1'b1;
      end
      frame_done = (c == t_done);
      #1;
      rp = exp_rp();
      n_vec++;
      if (reset_parser !== rp || frame_avl !== m_hold || frame_data !== m_data ||
          frame_triad_id !== IDW'(m_id) || timeout_evt !== m_to) begin
        n_err++;
        $display("FAIL rr_cycle c=%0d got rp=%b avl=%b id=%0d to=%b exp rp=%b avl=%b id=%0d to=%b",
                 c, reset_parser, frame_avl, frame_triad_id, timeout_evt, rp, m_hold, m_id, m_to);
      end
      if (frame_avl === 1'b1 && !prev_avl) got.push_back(int'(frame_triad_id));
      prev_avl = (frame_avl === 1'b1);
      for (int k = 0; k < N; k++)
        if (rp[k]) begin t_drop[k] = c + 2; t_raise[k] = c + 7; t_done = c + 5; end
      tick();
    end
    frame_done = 0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (got.size() <= i || got[i] != want[i]) begin
        n_err++;
        $display("FAIL rr_sequence idx=%0d got %0d expected %0d", i,
                 (got.size() > i) ? got[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_single_channel();
    logic [W-1:0] v = 102'h2A5;
    settle();
    for (int k = 0; k < N; k++) sensor_iterations[k*W +: W] = rand_frame();
    sensor_iterations[2*W +: W] = v;
    data_avl = 4'b0100;
    #1;
    n_vec++;
    if (reset_parser !== 4'b0100 || frame_avl !== 1'b0) begin
      n_err++; $display("FAIL single_grant got rp=%b avl=%b expected 0100 0", reset_parser, frame_avl);
    end
    tick();
    data_avl = '0;
    #1;
    n_vec++;
    if (reset_parser !== 4'b0000 || frame_avl !== 1'b1 || frame_triad_id !== 2'd2 || frame_data !== v) begin
      n_err++;
      $display("FAIL single_present got rp=%b avl=%b id=%0d data=%h expected 0000 1 2 %h",
               reset_parser, frame_avl, frame_triad_id, frame_data, v);
    end
    tick(); tick();
    frame_done = 1;
    #1;
    n_vec++;
    if (frame_avl !== 1'b1) begin n_err++; $display("FAIL single_hold got avl=%b expected 1", frame_avl); end
    tick();
    frame_done = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if (frame_avl !== 1'b0 || reset_parser !== 4'b0000) begin
        n_err++; $display("FAIL single_gap c=%0d got avl=%b rp=%b expected 0 0000", c, frame_avl, reset_parser);
      end
      tick();
    end
  endtask

  task automatic test_stale_hold();
    int pulses = 0;
    settle();
    for (int c = 0; c < 17; c++) begin
      data_avl = (c <= 10 || c >= 13) ? 4'b0010 : 4'b0000;
      frame_done = (c == 4);
      #1;
      n_vec++;
      if (reset_parser !== exp_rp() || frame_avl !== m_hold || frame_triad_id !== IDW'(m_id)) begin
        n_err++;
        $display("FAIL stale_cycle c=%0d got rp=%b avl=%b exp rp=%b avl=%b", c, reset_parser, frame_avl,
                 exp_rp(), m_hold);
      end
      if (c >= 1 && c <= 12 && reset_parser[1] === 1'b1) pulses++;
      if (c == 0 || c == 13) begin
        n_vec++;
        if (reset_parser !== 4'b0010) begin
          n_err++; $display("FAIL stale_grant c=%0d got rp=%b expected 0010", c, reset_parser);
        end
      end
      tick();
    end
    n_vec++;
    if (pulses != 0) begin n_err++; $display("FAIL stale_regrant got %0d pulses expected 0", pulses); end
    frame_done = 0;
  endtask

  task automatic test_buffer_overlap();
    logic [W-1:0] a;
    settle();
    a = rand_frame();
    sensor_iterations[0 +: W] = a;
    data_avl = 4'b0001;
    tick();
    for (int c = 0; c < 6; c++) begin
      data_avl = (c == 0) ? 4'b0000 : 4'b0001;
      sensor_iterations[0 +: W] = rand_frame();
      #1;
      n_vec++;
      if (frame_data !== a || frame_avl !== 1'b1 || frame_triad_id !== 2'd0) begin
        n_err++;
        $display("FAIL overlap_hold c=%0d got avl=%b id=%0d data=%h expected 1 0 %h",
                 c, frame_avl, frame_triad_id, frame_data, a);
      end
      tick();
    end
    frame_done = 1;
    tick();
    frame_done = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (reset_parser !== exp_rp() || frame_avl !== m_hold || frame_data !== m_data) begin
        n_err++;
        $display("FAIL overlap_after c=%0d got rp=%b avl=%b data=%h exp rp=%b avl=%b data=%h",
                 c, reset_parser, frame_avl, frame_data, exp_rp(), m_hold, m_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    settle();
    data_avl = 4'b0100;
    tick(); tick();
    data_avl = '1;
    rst_n = 0;
    #1;
    n_vec++;
    if (frame_avl !== 1'b0 || frame_data !== '0 || frame_triad_id !== '0 || reset_parser !== '0) begin
      n_err++;
      $display("FAIL reset_mid got avl=%b id=%0d rp=%b data=%h expected all 0",
               frame_avl, frame_triad_id, reset_parser, frame_data);
    end
    @(posedge clk_12MHz); #1;
    rst_n = 1; m_reset();
    #1;
    n_vec++;
    if (reset_parser !== 4'b0001) begin
      n_err++; $display("FAIL reset_first_grant got rp=%b expected 0001", reset_parser);
    end
    tick();
    #1;
    n_vec++;
    if (frame_avl !== 1'b1 || frame_triad_id !== 2'd0) begin
      n_err++; $display("FAIL reset_first_id got avl=%b id=%0d expected 1 0", frame_avl, frame_triad_id);
    end
  endtask

  task automatic test_random();
    settle();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k = $urandom_range(0, N-1);
        data_avl[k] = ~data_avl[k];
      end
      if ($urandom_range(0, 4) == 0) sensor_iterations[$urandom_range(0, N-1)*W +: W] = rand_frame();
      frame_done = ($urandom_range(0, 3) == 0);
      #1;
      n_vec++;
      if (reset_parser !== exp_rp() || frame_avl !== m_hold || frame_data !== m_data ||
          frame_triad_id !== IDW'(m_id) || timeout_evt !== m_to) begin
        n_err++;
        $display("FAIL random c=%0d got rp=%b avl=%b id=%0d to=%b data=%h exp rp=%b avl=%b id=%0d to=%b data=%h",
                 c, reset_parser, frame_avl, frame_triad_id, timeout_evt, frame_data,
                 exp_rp(), m_hold, m_id, m_to, m_data);
      end
      tick();
    end
    frame_done = 0;
  endtask

  task automatic test_timeout();
    int rise = -1, to_c = -1, id0 = -1, id1 = -1;
    bit prev_avl = 0;
    settle();
    data_avl = '1;
    for (int c = 0; c < 60; c++) begin
      #1;
      n_vec++;
      if (reset_parser !== exp_rp() || frame_avl !== m_hold || frame_triad_id !== IDW'(m_id) ||
          timeout_evt !== m_to) begin
        n_err++;
        $display("FAIL timeout_cycle c=%0d got rp=%b avl=%b id=%0d to=%b exp rp=%b avl=%b id=%0d to=%b",
                 c, reset_parser, frame_avl, frame_triad_id, timeout_evt, exp_rp(), m_hold, m_id, m_to);
      end
      if (frame_avl === 1'b1 && !prev_avl) begin
        if (rise < 0) begin rise = c; id0 = int'(frame_triad_id); end
        else if (id1 < 0) id1 = int'(frame_triad_id);
      end
      if (timeout_evt === 1'b1 && to_c < 0) to_c = c;
      prev_avl = (frame_avl === 1'b1);
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    n_vec++;
    if (rise < 0 || to_c - rise != TO) begin
      n_err++; $display("FAIL timeout_delay got %0d expected %0d", to_c - rise, TO);
    end
    n_vec++;
    if (id1 != (id0 + 1) % N) begin
      n_err++; $display("FAIL timeout_next got id=%0d expected %0d", id1, (id0 + 1) % N);
    end
`else
    n_vec++;
    if (to_c >= 0 || frame_avl !== 1'b1) begin
      n_err++; $display("FAIL no_timeout got to_cycle=%0d avl=%b expected -1 1", to_c, frame_avl);
    end
`endif
  endtask

  initial begin
    m_reset();
    test_reset();
    test_round_robin();
    test_single_channel();
    test_stale_hold();
    test_buffer_overlap();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/triad_frame_arbiter.md
Name: triad_frame_arbiter

Overview:
- Multi-triad successor to the single-triad path: collects finished sensor_iterations frames from N_TRIADS triad managers.
- Round-robin arbitration between triads; buffers one frame; presents it, tagged with the triad index, to the serial transmitter.
- Releases each triad parser (reset_parser) as soon as its frame is buffered, so parsing overlaps UART transmission.
- Sits in the 12 MHz domain between the triad_manager instances and the serial_transmitter; inputs are already synchronised to clk_12MHz.

Parameters:
- N_TRIADS, 4, number of triad channels (>=2).
- FRAME_W, 102, bits per sensor_iterations frame.
- ID_W, 2, triad index width; must satisfy 2**ID_W >= N_TRIADS.
- TIMEOUT_CYCLES, 1200000, transmitter ack timeout in clk cycles (100 ms); used only with ARB_TIMEOUT_EN.

Ports:
- clk_12MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_avl  in  N_TRIADS  per-triad frame-ready level.
- sensor_iterations  in  N_TRIADS*FRAME_W  flat frames; channel k occupies bits [k*FRAME_W +: FRAME_W].
- reset_parser  out  N_TRIADS  one-cycle release pulse to triad k.
- frame_avl  out  1  buffered frame valid (level).
- frame_data  out  FRAME_W  buffered frame.
- frame_triad_id  out  ID_W  source triad of frame_data.
- frame_done  in  1  one-cycle pulse from transmitter: frame consumed.
- timeout_evt  out  1  one-cycle pulse on ack timeout; constant 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async assert, sync deassert is upstream's concern):
  - reset_parser=0, frame_avl=0, frame_data=0, frame_triad_id=0, timeout_evt=0.
  - rr_ptr=0, release_mask=0, state=IDLE.
- Eligibility: eligible[k] = data_avl[k] & ~release_mask[k].
- release_mask[k]:
  - set on the cycle triad k is granted;
  - cleared on any cycle data_avl[k] is sampled 0 after the grant.
  - Prevents re-granting a frame whose data_avl has not yet dropped after reset_parser.
- Round robin: grant g = first eligible index searching rr_ptr, rr_ptr+1, ... wrapping modulo N_TRIADS (not modulo 2**ID_W).
- FSM states: IDLE, PRESENT, GAP.
  - IDLE, any eligible:
    - latch frame_data <= sensor_iterations[g], frame_triad_id <= g;
    - pulse reset_parser[g] for exactly one cycle; set release_mask[g];
    - rr_ptr <= (g==N_TRIADS-1) ? 0 : g+1; go to PRESENT.
    - frame_avl rises on the next edge, so frame_avl is high 1 cycle after data_avl is sampled.
  - IDLE, none eligible: stay; frame_done is ignored.
  - PRESENT: frame_avl=1; frame_data and frame_triad_id stable. On frame_done: frame_avl <= 0, go to GAP.
  - GAP: one cycle with frame_avl=0 so the transmitter sees a falling edge; then IDLE.
- Throughput: at most one grant per 3 cycles. With all channels continuously eligible, grants rotate 0,1,2,3,0,...
- Simultaneous events:
  - frame_done arriving in the same cycle IDLE grants is ignored (the FSM is not in PRESENT).
  - Clearing and re-setting release_mask[k] in the same cycle: set wins.
- reset_parser is never asserted for more than one cycle and never for two channels at once.
- rst_n asserted mid-frame: the buffered frame is discarded; no reset_parser pulse is issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - a counter runs in PRESENT and clears on entry;
  - if TIMEOUT_CYCLES elapse with no frame_done, pulse timeout_evt for 1 cycle, drop frame_avl, go to GAP (frame lost).
  - rr_ptr has already advanced, so the next channel gets service.
- Undefined: no counter; PRESENT waits indefinitely; timeout_evt tied 0.

Decomposition:
- Shared package (triad_pkg):
  - FRAME_W default 102;
  - FSM state encoding (IDLE=2'd0, PRESENT=2'd1, GAP=2'd2);
  - the default timeout constant.
- One natural sub-module: rr_arbiter (combinational-plus-pointer round-robin picker).
  - Inputs: eligible vector, rr_ptr.
  - Outputs: grant index, grant_valid.
  - Reusable for future multi-channel aggregation.

Test Plan:
- Single channel: data_avl=4'b0100, frame=102'h2A5 -> reset_parser=4'b0100 for 1 cycle; next cycle frame_avl=1, frame_triad_id=2, frame_data=102'h2A5; frame_done pulse -> frame_avl=0, stays 0 one cycle.
- Round robin: all data_avl high, each triad drops data_avl 2 cycles after its reset_parser and re-raises it 5 cycles later; frame_done 4 cycles after frame_avl -> frame_triad_id sequence 0,1,2,3,0,1.
- Stale hold: triad 1 keeps data_avl=1 for 10 cycles after reset_parser, others idle -> no second grant to triad 1 until data_avl[1] is seen low and re-raised.
- Buffer overlap: while PRESENT holds triad 0, new sensor_iterations are written on channel 0 -> frame_data unchanged until frame_done.
- Reset mid-PRESENT: rst_n low for 1 cycle -> frame_avl=0, rr_ptr=0, release_mask=0 immediately; after release with all eligible, first grant is triad 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, no frame_done -> timeout_evt pulse 16 cycles after frame_avl rises, frame_avl=0, next eligible channel granted.
